// File: rtl/memory_access_controller.sv
// ============================================================================
// memory_access_controller
//
// Initiator-side controller for a 32-word synchronous memory.  A requester
// hands over single-word or burst read/write commands through a valid/ready
// handshake.  The controller then owns the memory strobes. It sequences
// mem_wE / mem_rE one beat at a time and increments the address after each
// beat. Read data is returned on rd_data with one rd_valid pulse per word.
//
// Ports
//   clock          in   rising-edge system clock
//   reset          in   asynchronous, active-high reset
//   req_valid      in   command present
//   req_ready      out  command can be accepted (IDLE only)
//   req_write      in   1 = write burst, 0 = read burst
//   req_addr       in   start address
//   req_len        in   beats minus one
//   wr_data        in   write beat data
//   wr_data_valid  in   write beat present
//   wr_data_ready  out  write beat taken (WRITE only)
//   rd_data        out  read beat data
//   rd_valid       out  rd_data valid this cycle (no backpressure)
//   busy           out  controller not idle
//   done           out  one-cycle pulse when a burst completes
//   mem_address    out  memory address
//   mem_data       out  memory write data
//   mem_rE         out  memory read enable
//   mem_wE         out  memory write enable
//   mem_dataOut    in   memory read data
//
// Timing notes
//   All memory-side outputs are registered.  A strobe therefore becomes
//   visible the cycle after the FSM decides on it.
//   A read issued at edge En returns on rd_data/rd_valid after edge
//   E(n + READ_LATENCY + 1).  One tag bit per issued read travels through a
//   READ_LATENCY+1 deep shift pipe. The tag leaving the last stage marks
//   the edge at which mem_dataOut holds that beat.
//   done is a registered image of the DONE state, so it pulses the cycle
//   after DONE. That is one cycle after the last write strobe or the last
//   read beat.
// ============================================================================
module memory_access_controller #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 5,
    parameter int LEN_W        = 5,
    parameter int READ_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    // command channel
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    // write data channel
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_data_valid,
    output logic              wr_data_ready,
    // read data channel
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    // status
    output logic              busy,
    output logic              done,
    // memory side
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_rE,
    output logic              mem_wE,
    input  logic [DATA_W-1:0] mem_dataOut
);

    localparam int PIPE_D = READ_LATENCY + 1;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  LEN_ZERO  = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]  LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [PIPE_D-1:0] PIPE_ZERO = {PIPE_D{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cur_addr;
    logic [LEN_W-1:0]    r_remaining;
    logic                r_mem_rE;
    logic                r_mem_wE;
    logic [ADDR_W-1:0]   r_mem_address;
    logic [DATA_W-1:0]   r_mem_data;
    logic                r_done;
    logic [PIPE_D-1:0]   r_rd_pipe;
    logic                r_rd_valid;
    logic [DATA_W-1:0]   r_rd_data;

    logic                w_issue;
    logic                w_tag_exit;
    logic                w_pipe_pending;

    // A read is issued on every cycle spent in READ.
    assign w_issue        = (r_state == ST_READ);
    // The oldest tag leaves the pipe on this edge.
    assign w_tag_exit     = r_rd_pipe[PIPE_D-1];
    // Tags that are still in flight after this edge.  Nothing is issued
    // in DRAIN, so the pipe is empty after this edge when these are clear.
    assign w_pipe_pending = |r_rd_pipe[PIPE_D-2:0];

    // Status and handshake outputs are decoded straight from the state register.
    assign req_ready     = (r_state == ST_IDLE);
    assign wr_data_ready = (r_state == ST_WRITE);
    assign busy          = (r_state != ST_IDLE);

    assign mem_address   = r_mem_address;
    assign mem_data      = r_mem_data;
    assign mem_rE        = r_mem_rE;
    assign mem_wE        = r_mem_wE;
    assign done          = r_done;
    assign rd_valid      = r_rd_valid;
    assign rd_data       = r_rd_data;

    // Command FSM: accepts commands, sequences memory strobes, and counts
    // addresses and beats.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cur_addr    <= ADDR_ZERO;
            r_remaining   <= LEN_ZERO;
            r_mem_rE      <= 1'b0;
            r_mem_wE      <= 1'b0;
            r_mem_address <= ADDR_ZERO;
            r_mem_data    <= DATA_ZERO;
            r_done        <= 1'b0;
        end else begin
            // Strobes and done are single-cycle unless re-asserted below.
            r_mem_rE <= 1'b0;
            r_mem_wE <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_cur_addr  <= req_addr;
                        r_remaining <= req_len;
                        r_state     <= req_write ? ST_WRITE : ST_READ;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    // A stalled cycle leaves the address and count untouched.
                    if (wr_data_valid) begin
                        r_mem_wE      <= 1'b1;
                        r_mem_address <= r_cur_addr;
                        r_mem_data    <= wr_data;
                        r_cur_addr    <= r_cur_addr + ADDR_ONE;
                        if (r_remaining == LEN_ZERO) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_remaining <= r_remaining - LEN_ONE;
                        end
                    end else begin
                        r_state <= ST_WRITE;
                    end
                end
                ST_READ: begin
                    // Reads issue back-to-back, one per cycle. The address
                    // wraps from 31 to 0 naturally.
                    r_mem_rE      <= 1'b1;
                    r_mem_address <= r_cur_addr;
                    r_cur_addr    <= r_cur_addr + ADDR_ONE;
                    if (r_remaining == LEN_ZERO) begin
                        r_state <= ST_DRAIN;
                    end else begin
                        r_remaining <= r_remaining - LEN_ONE;
                    end
                end
                ST_DRAIN: begin
                    if (w_pipe_pending) begin
                        r_state <= ST_DRAIN;
                    end else begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read tag pipe and capture of returned memory data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_pipe  <= PIPE_ZERO;
            r_rd_valid <= 1'b0;
            r_rd_data  <= DATA_ZERO;
        end else begin
            r_rd_pipe  <= {r_rd_pipe[PIPE_D-2:0], w_issue};
            r_rd_valid <= w_tag_exit;
            if (w_tag_exit) begin
                r_rd_data <= mem_dataOut;
            end else begin
                r_rd_data <= r_rd_data;
            end
        end
    end

endmodule
